// File: rtl/al422_bam_scheduler.sv
// BAM scheduler for an AL422-fed LED panel: steps (row, plane) reads,
// overlaps shifting of the next plane with display of the current one.
module al422_bam_scheduler #(
    parameter int ROW_COUNT   = 16,
    parameter int BIT_DEPTH   = 8,
    parameter int BASE_DELAY  = 64,
    parameter int LATCH_WIDTH = 2
) (
    input  logic                         in_clk,
    input  logic                         in_nrst,
    input  logic                         enable,
    input  logic                         stage_busy,
    input  logic                         stage_row_ready,
    output logic                         module_start,
    output logic [2:0]                   bit_counter,
    output logic                         from_zero_address,
    output logic [$clog2(ROW_COUNT)-1:0] row_addr,
    output logic                         led_latch,
    output logic                         led_oe_n,
    output logic                         frame_done
);
    localparam int RW = $clog2(ROW_COUNT);
    localparam int TW = $clog2((BASE_DELAY << (BIT_DEPTH - 1)) + 1);
    localparam int LW = $clog2(LATCH_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        SHIFT,
        BLANK,
        LATCH,
        DRAIN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [RW-1:0] cur_row;
    logic [2:0]    cur_bit;
    logic [LW-1:0] latch_cnt;
    logic          latch_last;
    logic          last_plane;
    logic          frame_end;
    logic          timer_zero;

    assign timer_zero = (timer == '0);
    assign latch_last = (state == LATCH) &&
                        (latch_cnt == LW'(LATCH_WIDTH - 1));
    assign last_plane = (cur_row == RW'(ROW_COUNT - 1)) &&
                        (cur_bit == 3'(BIT_DEPTH - 1));
    assign frame_end  = latch_last && last_plane;

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (enable) state_nxt = START;
            START:     state_nxt = WAIT_BUSY;
            WAIT_BUSY: if (stage_busy) state_nxt = SHIFT;
            SHIFT: begin
                if (!stage_busy && stage_row_ready && timer_zero)
                    state_nxt = BLANK;
            end
            BLANK:     state_nxt = LATCH;
            LATCH: begin
                if (latch_last)
                    state_nxt = (frame_end && !enable) ? DRAIN : START;
            end
            DRAIN:     if (timer_zero) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        module_start      = (state == START);
        from_zero_address = (state == START) &&
                            (cur_row == '0) && (cur_bit == '0);
        bit_counter       = cur_bit;
        led_latch         = (state == LATCH);
        frame_done        = frame_end;
        // Timer is cleared asynchronously, so reset blanks at once
        led_oe_n          = timer_zero;
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            timer     <= '0;
            cur_row   <= '0;
            cur_bit   <= '0;
            latch_cnt <= '0;
            row_addr  <= '0;
        end else begin
            if (latch_last) begin
                timer <= TW'(BASE_DELAY) << cur_bit;
            end else if (!timer_zero) begin
                timer <= timer - TW'(1);
            end

            if (state == LATCH) begin
                latch_cnt <= latch_cnt + LW'(1);
            end else begin
                latch_cnt <= '0;
            end

            if (state == BLANK) begin
                row_addr <= cur_row;
            end

            if (state == IDLE && enable) begin
                cur_row <= '0;
                cur_bit <= '0;
            end else if (latch_last) begin
                if (cur_bit == 3'(BIT_DEPTH - 1)) begin
                    cur_bit <= '0;
                    cur_row <= (cur_row == RW'(ROW_COUNT - 1)) ?
                               '0 : cur_row + RW'(1);
                end else begin
                    cur_bit <= cur_bit + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_al422_bam_scheduler.sv
// Bench for al422_bam_scheduler: random first-stage busy times checked
// against a plane-order / on-time reference built from plain arithmetic.
module tb_al422_bam_scheduler;
    localparam int ROWS = 2;
    localparam int BITS = 3;
    localparam int BASE = 4;
    localparam int LWID = 2;
    localparam int NPL  = ROWS * BITS;

    logic       in_clk = 1'b0;
    logic       in_nrst = 1'b0;
    logic       enable = 1'b0;
    logic       stage_busy;
    logic       stage_row_ready;
    logic       module_start;
    logic [2:0] bit_counter;
    logic       from_zero_address;
    logic [0:0] row_addr;
    logic       led_latch;
    logic       led_oe_n;
    logic       frame_done;

    al422_bam_scheduler #(
        .ROW_COUNT(ROWS), .BIT_DEPTH(BITS),
        .BASE_DELAY(BASE), .LATCH_WIDTH(LWID)
    ) dut (
        .in_clk(in_clk), .in_nrst(in_nrst), .enable(enable),
        .stage_busy(stage_busy), .stage_row_ready(stage_row_ready),
        .module_start(module_start), .bit_counter(bit_counter),
        .from_zero_address(from_zero_address), .row_addr(row_addr),
        .led_latch(led_latch), .led_oe_n(led_oe_n),
        .frame_done(frame_done)
    );

    always #5 in_clk = ~in_clk;

    int n_checks = 0;
    int n_fail = 0;
    int busy_len = 10;

    // First-stage model: busy for busy_len cycles after a start
    int busy_cnt;
    always @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            busy_cnt <= 0;
            stage_busy <= 1'b0;
            stage_row_ready <= 1'b0;
        end else if (module_start) begin
            busy_cnt <= busy_len;
            stage_busy <= 1'b1;
            stage_row_ready <= 1'b0;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt <= 0;
            stage_busy <= 1'b0;
            stage_row_ready <= 1'b1;
        end
    end

    // Monitor: event logs sampled on the falling edge
    int st_bit[$];
    int st_fza[$];
    int la_row[$];
    int la_bit[$];
    int la_len[$];
    int on_len[$];
    int off_len[$];
    int fd_cnt = 0;
    int v_latch = 0;
    int v_row = 0;
    int v_busy = 0;
    int lo_cnt = 0;
    int hi_cnt = 0;
    int la_cnt = 0;
    logic prev_oe = 1'b1;
    logic prev_la = 1'b0;
    logic [0:0] prev_row = '0;

    always @(negedge in_clk) begin
        if (!in_nrst) begin
            lo_cnt = 0;
            hi_cnt = 0;
            la_cnt = 0;
            prev_oe = 1'b1;
            prev_la = 1'b0;
            prev_row = row_addr;
        end else begin
            if (module_start) begin
                st_bit.push_back(int'(bit_counter));
                st_fza.push_back(int'(from_zero_address));
                if (stage_busy) v_busy++;
            end
            if (frame_done) fd_cnt++;
            if (led_latch && !led_oe_n) v_latch++;
            if (row_addr !== prev_row &&
                !(led_oe_n && prev_oe && led_latch && !prev_la))
                v_row++;
            if (led_latch) begin
                if (!prev_la) begin
                    la_row.push_back(int'(row_addr));
                    la_bit.push_back(int'(bit_counter));
                end
                la_cnt++;
            end else if (prev_la) begin
                la_len.push_back(la_cnt);
                la_cnt = 0;
            end
            if (!led_oe_n) begin
                if (prev_oe) begin
                    off_len.push_back(hi_cnt);
                    hi_cnt = 0;
                end
                lo_cnt++;
            end else begin
                if (!prev_oe) begin
                    on_len.push_back(lo_cnt);
                    lo_cnt = 0;
                end
                hi_cnt++;
            end
            prev_oe = led_oe_n;
            prev_la = led_latch;
            prev_row = row_addr;
        end
    end

    // Reference plane order: plane index b inside row r
    int exp_row[NPL];
    int exp_bit[NPL];

    task automatic test_reset();
        int t;
        enable = 1'b1;
        repeat (3) @(negedge in_clk);
        n_checks++;
        if (module_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_start: got %b, expected 0", module_start);
        end
        n_checks++;
        if (bit_counter !== 3'd0) begin
            n_fail++;
            $display("FAIL rst_bit: got %0d, expected 0", bit_counter);
        end
        n_checks++;
        if (from_zero_address !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_fza: got %b, expected 0", from_zero_address);
        end
        n_checks++;
        if (row_addr !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_row: got %0d, expected 0", row_addr);
        end
        n_checks++;
        if (led_latch !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_latch: got %b, expected 0", led_latch);
        end
        n_checks++;
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_done: got %b, expected 0", frame_done);
        end
        n_checks++;
        if (led_oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_oe: got %b, expected 1", led_oe_n);
        end
        enable = 1'b0;
        @(negedge in_clk);
        in_nrst = 1'b1;
        t = 0;
        repeat (20) @(negedge in_clk);
        n_checks++;
        if (st_bit.size() != 0 || led_oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_no_start: starts %0d oe %b, expected 0 1",
                     st_bit.size(), led_oe_n);
        end
    endtask

    task automatic test_full_frame();
        int s0 = st_bit.size();
        int l0 = la_row.size();
        int o0 = on_len.size();
        int f0 = fd_cnt;
        int t = 0;
        busy_len = $urandom_range(8, 12);
        @(negedge in_clk);
        enable = 1'b1;
        while (st_bit.size() < s0 + NPL + 1 && t < 3000) begin
            @(negedge in_clk);
            t++;
        end
        enable = 1'b0;
        t = 0;
        while ((fd_cnt < f0 + 2 || on_len.size() < o0 + 2 * NPL) &&
               t < 3000) begin
            @(negedge in_clk);
            t++;
        end
        repeat (100) @(negedge in_clk);
        n_checks++;
        if (on_len.size() < o0 + 2 * NPL || la_row.size() < l0 + 2 * NPL ||
            st_bit.size() < s0 + 2 * NPL) begin
            n_fail++;
            $display("FAIL frame_timeout: on-times %0d, expected %0d",
                     on_len.size() - o0, 2 * NPL);
        end else begin
            for (int i = 0; i < 2 * NPL; i++) begin
                int p = i % NPL;
                int fz = (p == 0) ? 1 : 0;
                n_checks++;
                if (st_bit[s0+i] != exp_bit[p] || st_fza[s0+i] != fz) begin
                    n_fail++;
                    $display("FAIL start_%0d: got bit %0d fza %0d, expected %0d %0d",
                             i, st_bit[s0+i], st_fza[s0+i], exp_bit[p], fz);
                end
                n_checks++;
                if (la_row[l0+i] != exp_row[p] || la_bit[l0+i] != exp_bit[p]) begin
                    n_fail++;
                    $display("FAIL latch_%0d: got row %0d bit %0d, expected %0d %0d",
                             i, la_row[l0+i], la_bit[l0+i], exp_row[p], exp_bit[p]);
                end
                n_checks++;
                if (on_len[o0+i] != (BASE << exp_bit[p])) begin
                    n_fail++;
                    $display("FAIL ontime_%0d: got %0d, expected %0d",
                             i, on_len[o0+i], BASE << exp_bit[p]);
                end
            end
        end
        n_checks++;
        if (st_bit.size() != s0 + 2 * NPL || fd_cnt != f0 + 2) begin
            n_fail++;
            $display("FAIL frame_totals: got starts %0d done %0d, expected %0d 2",
                     st_bit.size() - s0, fd_cnt - f0, 2 * NPL);
        end
        n_checks++;
        if (led_oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_idle_oe: got %b, expected 1", led_oe_n);
        end
    endtask

    task automatic test_slow_stage();
        int s0 = st_bit.size();
        int o0 = on_len.size();
        int g0 = off_len.size();
        int f0 = fd_cnt;
        int t = 0;
        busy_len = $urandom_range(35, 45);
        @(negedge in_clk);
        enable = 1'b1;
        while (st_bit.size() <= s0 && t < 200) begin
            @(negedge in_clk);
            t++;
        end
        enable = 1'b0;
        t = 0;
        while ((fd_cnt <= f0 || on_len.size() < o0 + NPL) && t < 3000) begin
            @(negedge in_clk);
            t++;
        end
        repeat (100) @(negedge in_clk);
        n_checks++;
        if (st_bit.size() != s0 + NPL || on_len.size() != o0 + NPL ||
            off_len.size() < g0 + NPL) begin
            n_fail++;
            $display("FAIL slow_counts: got starts %0d on %0d, expected %0d",
                     st_bit.size() - s0, on_len.size() - o0, NPL);
        end else begin
            for (int k = 0; k < NPL; k++) begin
                n_checks++;
                if (st_bit[s0+k] != exp_bit[k] || on_len[o0+k] != (BASE << exp_bit[k])) begin
                    n_fail++;
                    $display("FAIL slow_plane_%0d: got bit %0d on %0d, expected %0d %0d",
                             k, st_bit[s0+k], on_len[o0+k], exp_bit[k], BASE << exp_bit[k]);
                end
                if (k > 0) begin
                    n_checks++;
                    if (off_len[g0+k] <= busy_len - (BASE << exp_bit[k-1])) begin
                        n_fail++;
                        $display("FAIL slow_gap_%0d: got %0d, expected above %0d",
                                 k, off_len[g0+k], busy_len - (BASE << exp_bit[k-1]));
                    end
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        int s0 = st_bit.size();
        int o0 = on_len.size();
        int f0 = fd_cnt;
        int t = 0;
        busy_len = $urandom_range(6, 14);
        @(negedge in_clk);
        enable = 1'b1;
        while (st_bit.size() < s0 + 2 && t < 500) begin
            @(negedge in_clk);
            t++;
        end
        enable = 1'b0;
        t = 0;
        while ((fd_cnt <= f0 || on_len.size() < o0 + NPL) && t < 3000) begin
            @(negedge in_clk);
            t++;
        end
        repeat (100) @(negedge in_clk);
        n_checks++;
        if (fd_cnt != f0 + 1) begin
            n_fail++;
            $display("FAIL drop_done: got %0d pulses, expected 1", fd_cnt - f0);
        end
        n_checks++;
        if (st_bit.size() != s0 + NPL) begin
            n_fail++;
            $display("FAIL drop_starts: got %0d, expected %0d",
                     st_bit.size() - s0, NPL);
        end
        n_checks++;
        if (on_len.size() != o0 + NPL) begin
            n_fail++;
            $display("FAIL drop_ontimes: got %0d, expected %0d",
                     on_len.size() - o0, NPL);
        end else begin
            n_checks++;
            if (on_len[o0+NPL-1] != (BASE << (BITS - 1))) begin
                n_fail++;
                $display("FAIL drop_last_on: got %0d, expected %0d",
                         on_len[o0+NPL-1], BASE << (BITS - 1));
            end
        end
        n_checks++;
        if (led_oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_idle_oe: got %b, expected 1", led_oe_n);
        end
    endtask

    task automatic test_reset_mid();
        int l0 = la_bit.size();
        int s1;
        int f1;
        int t = 0;
        busy_len = $urandom_range(8, 12);
        @(negedge in_clk);
        enable = 1'b1;
        while (la_bit.size() < l0 + 3 && t < 1000) begin
            @(negedge in_clk);
            t++;
        end
        t = 0;
        while (led_oe_n !== 1'b0 && t < 20) begin
            @(negedge in_clk);
            t++;
        end
        repeat ($urandom_range(1, 10)) @(negedge in_clk);
        n_checks++;
        if (led_oe_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_pre_oe: got %b, expected 0", led_oe_n);
        end
        #2 in_nrst = 1'b0;
        #1;
        n_checks++;
        if (led_oe_n !== 1'b1 || led_latch !== 1'b0 || module_start !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_blank: got oe %b latch %b start %b, expected 1 0 0",
                     led_oe_n, led_latch, module_start);
        end
        repeat (2) @(negedge in_clk);
        s1 = st_bit.size();
        in_nrst = 1'b1;
        t = 0;
        while (st_bit.size() <= s1 && t < 50) begin
            @(negedge in_clk);
            t++;
        end
        n_checks++;
        if (st_bit.size() <= s1) begin
            n_fail++;
            $display("FAIL mid_restart: got no start, expected one");
        end else if (st_fza[s1] != 1 || st_bit[s1] != 0) begin
            n_fail++;
            $display("FAIL mid_restart: got fza %0d bit %0d, expected 1 0",
                     st_fza[s1], st_bit[s1]);
        end
        f1 = fd_cnt;
        enable = 1'b0;
        t = 0;
        while (fd_cnt <= f1 && t < 3000) begin
            @(negedge in_clk);
            t++;
        end
        repeat (100) @(negedge in_clk);
        n_checks++;
        if (fd_cnt != f1 + 1 || led_oe_n !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_drain: got done %0d oe %b, expected 1 1",
                     fd_cnt - f1, led_oe_n);
        end
    endtask

    task automatic test_latch_rules();
        int bad = 0;
        foreach (la_len[i]) if (la_len[i] != LWID) bad++;
        n_checks++;
        if (bad != 0 || la_len.size() == 0) begin
            n_fail++;
            $display("FAIL latch_width: got %0d bad of %0d, expected 0 bad",
                     bad, la_len.size());
        end
        n_checks++;
        if (v_latch != 0) begin
            n_fail++;
            $display("FAIL latch_while_on: got %0d, expected 0", v_latch);
        end
        n_checks++;
        if (v_row != 0) begin
            n_fail++;
            $display("FAIL row_change: got %0d, expected 0", v_row);
        end
        n_checks++;
        if (v_busy != 0) begin
            n_fail++;
            $display("FAIL start_while_busy: got %0d, expected 0", v_busy);
        end
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < BITS; b++) begin
                exp_row[r*BITS+b] = r;
                exp_bit[r*BITS+b] = b;
            end
        end
        test_reset();
        test_full_frame();
        test_slow_stage();
        test_enable_drop();
        test_reset_mid();
        test_latch_rules();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule
